// File: rtl/sensor_regbank_pkg.sv
// Shared constants, read-response type and address-map helpers for the sensor register bank.
package sensor_regbank_pkg;

    // Fixed identification byte returned at address 0.
    localparam logic [7:0] ID_BYTE = 8'hA5;

    // Byte-address map offsets.
    localparam int ADDR_ID        = 0;
    localparam int ADDR_NCH       = 1;
    localparam int ADDR_FRESH     = 2;
    localparam int ADDR_OVR       = 3;
    localparam int ADDR_DATA_BASE = 4;

    // Registered read response: ack qualifies data, err flags an out-of-range address.
    typedef struct packed {
        logic       ack;
        logic       err;
        logic [7:0] data;
    } rd_resp_t;

    // Highest byte address that maps to real content.
    function automatic int last_valid_addr(input int num_ch, input int ch_bytes);
        return ADDR_DATA_BASE + num_ch * ch_bytes - 1;
    endfunction

    // Fold up to 32 fresh flags onto one byte: bit i is the OR of channels i, i+8, i+16, i+24.
    function automatic logic [7:0] fold_fresh(input logic [31:0] f);
        return f[7:0] | f[15:8] | f[23:16] | f[31:24];
    endfunction

endpackage

// File: rtl/sensor_chan_reg.sv
// One sensor channel: live sample register, fresh/overrun tracking and the shadow copy
// that a snapshot freezes for the read side.
module sensor_chan_reg
    import sensor_regbank_pkg::*;
#(
    parameter int CH_BYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [CH_BYTES*8-1:0] sample_i,
    input  logic                  snap_i,
    output logic [CH_BYTES*8-1:0] shadow_data_o,
    output logic                  shadow_fresh_o,
    output logic                  shadow_ovr_o
);

    localparam int CH_W = CH_BYTES * 8;

    logic [CH_W-1:0] live_q, live_d;
    logic            fresh_q, fresh_d;
    logic            ovr_q, ovr_d;
    logic [CH_W-1:0] shadow_data_q, shadow_data_d;
    logic            shadow_fresh_q, shadow_fresh_d;
    logic            shadow_ovr_q, shadow_ovr_d;

    // Next-state for live side. A sample arriving with a snapshot belongs to the new
    // interval: it keeps fresh set and starts a clean overrun count.
    always_comb begin
        live_d  = valid_i ? sample_i : live_q;
        fresh_d = valid_i | (fresh_q & ~snap_i);
        ovr_d   = snap_i ? 1'b0 : (ovr_q | (valid_i & fresh_q));
    end

    // Next-state for shadow side: capture pre-update live state on a snapshot.
    always_comb begin
        shadow_data_d  = shadow_data_q;
        shadow_fresh_d = shadow_fresh_q;
        shadow_ovr_d   = shadow_ovr_q;
        if (snap_i) begin
            shadow_data_d  = live_q;
            shadow_fresh_d = fresh_q;
            shadow_ovr_d   = ovr_q;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q         <= '0;
            fresh_q        <= 1'b0;
            ovr_q          <= 1'b0;
            shadow_data_q  <= '0;
            shadow_fresh_q <= 1'b0;
            shadow_ovr_q   <= 1'b0;
        end else begin
            live_q         <= live_d;
            fresh_q        <= fresh_d;
            ovr_q          <= ovr_d;
            shadow_data_q  <= shadow_data_d;
            shadow_fresh_q <= shadow_fresh_d;
            shadow_ovr_q   <= shadow_ovr_d;
        end
    end

    assign shadow_data_o  = shadow_data_q;
    assign shadow_fresh_o = shadow_fresh_q;
    assign shadow_ovr_o   = shadow_ovr_q;

endmodule

// File: rtl/sensor_regbank.sv
// Sensor register bank: per-channel live capture, coherent snapshot into shadow
// registers, and a byte-wide registered read port over the shadow state only.
module sensor_regbank
    import sensor_regbank_pkg::*;
#(
    parameter int NUM_CH   = 12,
    parameter int CH_BYTES = 2,
    parameter int ADDR_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*CH_BYTES*8-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic                         snap_req,
    output logic                         snap_done,
    input  logic                         rd_req,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         rd_ack,
    output logic [7:0]                   rd_data,
    output logic                         rd_err
);

    localparam int CH_W      = CH_BYTES * 8;
    localparam int NUM_BYTES = NUM_CH * CH_BYTES;
    localparam int LAST_ADDR = last_valid_addr(NUM_CH, CH_BYTES);
    localparam logic [ADDR_W:0] LAST_ADDR_V = (ADDR_W + 1)'(LAST_ADDR);

    // Parameter sanity checks at elaboration.
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("sensor_regbank: NUM_CH must be in 1..32");
    end
    if (CH_BYTES < 1 || CH_BYTES > 4) begin : g_bad_ch_bytes
        $error("sensor_regbank: CH_BYTES must be in 1..4");
    end
    if (ADDR_DATA_BASE + NUM_BYTES > 2 ** ADDR_W) begin : g_bad_addr_w
        $error("sensor_regbank: ADDR_W too narrow for the address map");
    end

    logic [CH_W-1:0]   shadow_data [NUM_CH];
    logic [NUM_CH-1:0] shadow_fresh;
    logic [NUM_CH-1:0] shadow_ovr;
    logic [7:0]        data_bytes  [NUM_BYTES];

    // One channel slice per sensor input.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        sensor_chan_reg #(
            .CH_BYTES(CH_BYTES)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .valid_i       (ch_valid[gi]),
            .sample_i      (ch_data[gi*CH_W +: CH_W]),
            .snap_i        (snap_req),
            .shadow_data_o (shadow_data[gi]),
            .shadow_fresh_o(shadow_fresh[gi]),
            .shadow_ovr_o  (shadow_ovr[gi])
        );
    end

    // Flat byte view of the shadow data, most-significant byte of each channel first.
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
        assign data_bytes[gi] =
            shadow_data[gi / CH_BYTES][(CH_BYTES - 1 - (gi % CH_BYTES)) * 8 +: 8];
    end

    logic [7:0] fresh_byte;
    logic [7:0] ovr_byte;
    logic [7:0] data_sel;
    logic       addr_oor;
    rd_resp_t   rd_q, rd_d;
    logic       snap_done_q, snap_done_d;

    assign fresh_byte = fold_fresh(32'(shadow_fresh));
    assign ovr_byte   = {7'b0, |shadow_ovr};
    assign addr_oor   = {1'b0, rd_addr} > LAST_ADDR_V;

    // Select the addressed channel byte from the data region.
    always_comb begin
        data_sel = 8'h00;
        for (int j = 0; j < NUM_BYTES; j++) begin
            if (rd_addr == ADDR_W'(ADDR_DATA_BASE + j)) begin
                data_sel = data_bytes[j];
            end
        end
    end

    // Read response next-state; data holds its last value when no read is issued.
    always_comb begin
        rd_d      = rd_q;
        rd_d.ack  = rd_req;
        rd_d.err  = 1'b0;
        if (rd_req) begin
            if (addr_oor) begin
                rd_d.err  = 1'b1;
                rd_d.data = 8'h00;
            end else if (rd_addr == ADDR_W'(ADDR_ID)) begin
                rd_d.data = ID_BYTE;
            end else if (rd_addr == ADDR_W'(ADDR_NCH)) begin
                rd_d.data = 8'(NUM_CH);
            end else if (rd_addr == ADDR_W'(ADDR_FRESH)) begin
                rd_d.data = fresh_byte;
            end else if (rd_addr == ADDR_W'(ADDR_OVR)) begin
                rd_d.data = ovr_byte;
            end else begin
                rd_d.data = data_sel;
            end
        end
    end

    // Snapshot completion pulses once per accepted snapshot request.
    always_comb begin
        snap_done_d = snap_req;
    end

    // Output registers; reset discards any read or snapshot in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q        <= '0;
            snap_done_q <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            snap_done_q <= snap_done_d;
        end
    end

    assign rd_ack    = rd_q.ack;
    assign rd_err    = rd_q.err;
    assign rd_data   = rd_q.data;
    assign snap_done = snap_done_q;

endmodule

// File: tb/tb_sensor_regbank.sv
// Self-checking bench for sensor_regbank: directed scenarios followed by random traffic,
// all compared against a sample-count based reference model.
module tb_sensor_regbank;

    localparam int NUM_CH    = 12;
    localparam int CH_BYTES  = 2;
    localparam int ADDR_W    = 8;
    localparam int MAP_BYTES = 4 + NUM_CH * CH_BYTES;

    logic                         clk;
    logic                         rst;
    logic [NUM_CH*CH_BYTES*8-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_valid;
    logic                         snap_req;
    logic                         snap_done;
    logic                         rd_req;
    logic [ADDR_W-1:0]            rd_addr;
    logic                         rd_ack;
    logic [7:0]                   rd_data;
    logic                         rd_err;

    int checks = 0;
    int errors = 0;

    // Reference model: live values, samples counted since the last snapshot, shadow copy.
    logic [15:0] live_m   [NUM_CH];
    int          cnt_m    [NUM_CH];
    logic [15:0] sh_val   [NUM_CH];
    bit          sh_fresh [NUM_CH];
    bit          sh_ovr   [NUM_CH];
    logic        exp_ack, exp_err, exp_done;
    logic [7:0]  exp_data;

    sensor_regbank #(
        .NUM_CH  (NUM_CH),
        .CH_BYTES(CH_BYTES),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_data  (ch_data),
        .ch_valid (ch_valid),
        .snap_req (snap_req),
        .snap_done(snap_done),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .rd_err   (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            live_m[k]   = '0;
            cnt_m[k]    = 0;
            sh_val[k]   = '0;
            sh_fresh[k] = 0;
            sh_ovr[k]   = 0;
        end
        exp_ack  = 0;
        exp_err  = 0;
        exp_done = 0;
        exp_data = 8'h00;
    endtask

    function automatic logic [7:0] model_read(input int a);
        logic [7:0] r;
        int k, b;
        r = 8'h00;
        if (a == 0) r = 8'hA5;
        else if (a == 1) r = 8'(NUM_CH);
        else if (a == 2) begin
            for (int c = 0; c < NUM_CH; c++) if (sh_fresh[c]) r[c % 8] = 1'b1;
        end else if (a == 3) begin
            for (int c = 0; c < NUM_CH; c++) if (sh_ovr[c]) r[0] = 1'b1;
        end else if (a < MAP_BYTES) begin
            k = (a - 4) / CH_BYTES;
            b = (a - 4) % CH_BYTES;
            r = 8'(sh_val[k] >> (8 * (CH_BYTES - 1 - b)));
        end
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs presented for that edge.
    task automatic model_step();
        exp_ack  = rd_req;
        exp_err  = 0;
        exp_done = snap_req;
        if (rd_req) begin
            exp_err  = (int'(rd_addr) >= MAP_BYTES);
            exp_data = model_read(int'(rd_addr));
        end
        if (snap_req) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sh_val[k]   = live_m[k];
                sh_fresh[k] = (cnt_m[k] >= 1);
                sh_ovr[k]   = (cnt_m[k] >= 2);
                cnt_m[k]    = 0;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_valid[k]) begin
                live_m[k] = ch_data[k*16 +: 16];
                if (cnt_m[k] < 2) cnt_m[k]++;
            end
        end
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge, pulses cleared.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("rd_ack", {31'b0, rd_ack}, {31'b0, exp_ack});
        check("rd_err", {31'b0, rd_err}, {31'b0, exp_err});
        check("rd_data", {24'b0, rd_data}, {24'b0, exp_data});
        check("snap_done", {31'b0, snap_done}, {31'b0, exp_done});
        rd_req   = 0;
        snap_req = 0;
        ch_valid = '0;
    endtask

    task automatic sample(input int k, input logic [15:0] v);
        ch_valid[k]       = 1'b1;
        ch_data[k*16 +: 16] = v;
    endtask

    task automatic snap();
        snap_req = 1;
        tick();
    endtask

    task automatic rd(input int a, input logic [7:0] want, input string tag);
        rd_req  = 1;
        rd_addr = 8'(a);
        tick();
        check(tag, {24'b0, rd_data}, {24'b0, want});
    endtask

    initial begin
        rst      = 1;
        ch_data  = '0;
        ch_valid = '0;
        snap_req = 0;
        rd_req   = 0;
        rd_addr  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_ack", {31'b0, rd_ack}, 32'd0);
        check("reset_data", {24'b0, rd_data}, 32'd0);
        check("reset_err", {31'b0, rd_err}, 32'd0);
        check("reset_done", {31'b0, snap_done}, 32'd0);
        rst = 0;

        // Identity and empty data after reset.
        rd(0, 8'hA5, "id_byte");
        rd(1, 8'h0C, "num_ch");
        rd(4, 8'h00, "ch0_after_reset");

        // Single sample, snapshot, read back.
        sample(0, 16'h1234); tick();
        snap();
        rd(4, 8'h12, "ch0_msb");
        rd(5, 8'h34, "ch0_lsb");
        rd(2, 8'h01, "fresh_ch0");
        rd(3, 8'h00, "ovr_clear");

        // Overrun from two samples between snapshots, then cleared.
        sample(3, 16'h0001); tick();
        sample(3, 16'hBEEF); tick();
        snap();
        rd(10, 8'hBE, "ch3_msb");
        rd(11, 8'hEF, "ch3_lsb");
        rd(3, 8'h01, "ovr_set");
        snap();
        rd(3, 8'h00, "ovr_cleared");

        // Sample coinciding with snapshot: snapshot sees the older value.
        sample(2, 16'hAAAA); tick();
        snap();
        sample(2, 16'h5555); snap_req = 1; tick();
        rd(8, 8'hAA, "ch2_pre_update");
        snap();
        rd(8, 8'h55, "ch2_post_update");
        rd(2, 8'h04, "fresh_kept_ch2");

        // Read coinciding with snapshot returns the old shadow.
        sample(5, 16'hC0DE); tick();
        rd_req = 1; rd_addr = 8'd14; snap_req = 1; tick();
        check("rd_with_snap", {24'b0, rd_data}, 32'h00);
        rd(14, 8'hC0, "ch5_after_snap");

        // Back-to-back snapshots.
        sample(1, 16'h0101); tick();
        snap();
        snap();
        rd(2, 8'h00, "fresh_after_double_snap");
        rd(6, 8'h01, "ch1_msb");

        // Last valid address and first out-of-range address back to back.
        rd_req = 1; rd_addr = 8'd27; tick();
        check("ack_addr27", {31'b0, rd_ack}, 32'd1);
        check("err_addr27", {31'b0, rd_err}, 32'd0);
        rd_req = 1; rd_addr = 8'd28; tick();
        check("ack_addr28", {31'b0, rd_ack}, 32'd1);
        check("err_addr28", {31'b0, rd_err}, 32'd1);
        check("data_addr28", {24'b0, rd_data}, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 5) == 0) sample(k, 16'($urandom));
            end
            snap_req = ($urandom_range(0, 6) == 0);
            rd_req   = 1'($urandom_range(0, 1));
            rd_addr  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 29));
            tick();
        end

        // Reset while a read and a snapshot are in flight.
        rd(0, 8'hA5, "id_before_reset");
        rd_req = 1; rd_addr = 8'd0; snap_req = 1;
        sample(0, 16'h7777);
        @(posedge clk);
        #1;
        rst = 1; rd_req = 0; snap_req = 0; ch_valid = '0;
        @(negedge clk);
        check("inflight_ack", {31'b0, rd_ack}, 32'd0);
        check("inflight_done", {31'b0, snap_done}, 32'd0);
        check("inflight_data", {24'b0, rd_data}, 32'd0);
        check("inflight_err", {31'b0, rd_err}, 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();
        tick();
        snap();
        rd(2, 8'h00, "fresh_after_reset");
        rd(3, 8'h00, "ovr_after_reset");
        rd(4, 8'h00, "ch0_after_midreset");
        rd(0, 8'hA5, "id_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sensor_regbank.md
SENSOR_REGBANK -- requirements
Module: sensor_regbank

Interface
REQ-001 Parameter NUM_CH, default 12, number of sensor channels (1..32).
REQ-002 Parameter CH_BYTES, default 2, bytes per channel (1..4).
REQ-003 Parameter ADDR_W, default 8, read-address width; 4 + NUM_CH*CH_BYTES SHALL not exceed 2**ADDR_W (elaboration-time check).
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, reset: asynchronous, active-high.
REQ-006 Port ch_data, input, NUM_CH*CH_BYTES*8, flattened channel samples; channel k occupies bits [(k+1)*CH_BYTES*8-1 : k*CH_BYTES*8].
REQ-007 Port ch_valid, input, NUM_CH, per-channel one-cycle strobe: the corresponding ch_data slice is a new sample.
REQ-008 Port snap_req, input, 1, one-cycle pulse: take a coherent snapshot of all channels.
REQ-009 Port snap_done, output, 1, one-cycle pulse, the cycle after the snapshot is taken.
REQ-010 Port rd_req, input, 1, read strobe; accepted every cycle.
REQ-011 Port rd_addr, input, ADDR_W, byte address, sampled with rd_req.
REQ-012 Port rd_ack, output, 1, one-cycle pulse qualifying rd_data.
REQ-013 Port rd_data, output, 8, read byte; holds its value between reads.
REQ-014 Port rd_err, output, 1, pulse with rd_ack when rd_addr is out of range.

Function
REQ-015 A live register per channel SHALL load its ch_data slice on any cycle where its ch_valid bit is high, and SHALL set that channel's fresh flag.
REQ-016 On snap_req, all live registers SHALL be copied into shadow registers, and all fresh flags into shadow flags, in one cycle; all live fresh flags SHALL then clear.
REQ-017 When ch_valid[k] and snap_req are high in the same cycle, the snapshot SHALL capture the pre-update live value and fresh flag, and fresh[k] SHALL remain set after the cycle.
REQ-018 When ch_valid[k] pulses twice or more between snapshots, ovr[k] SHALL set (sticky); ovr SHALL be copied to shadow and cleared on snap_req under the same rules as fresh.
REQ-019 Reads SHALL access shadow state only; live values never reach rd_data.
REQ-020 Address map: 0 = ID byte 0xA5; 1 = NUM_CH; 2 = shadow fresh flags, channels 7..0 packed as an OR of 4-channel groups; 3 = OR of all shadow ovr bits in bit 0, bits 7..1 = 0; 4 + k*CH_BYTES + b = channel k byte b, where b=0 is the MSB.
REQ-021 For NUM_CH > 8, byte 2 bit i SHALL be the OR of fresh[i], fresh[i+8], fresh[i+16] and fresh[i+24].
REQ-022 Read latency: rd_ack, rd_data and rd_err SHALL be registered, asserting exactly one cycle after rd_req; back-to-back reads SHALL give back-to-back acks.
REQ-023 Out-of-range address (at or above 4 + NUM_CH*CH_BYTES): rd_data SHALL be 0x00 and rd_err SHALL be 1 with rd_ack.
REQ-024 When rd_req and snap_req are high in the same cycle, the read SHALL return the pre-snapshot shadow contents.
REQ-025 snap_req pulses in consecutive cycles SHALL each take a snapshot; snap_done SHALL pulse for each.

Reset
REQ-026 rst SHALL asynchronously clear all live, shadow, fresh and ovr state, and SHALL drive rd_data = 0x00 and rd_ack = rd_err = snap_done = 0.
REQ-027 A read or snapshot in flight when rst asserts SHALL be discarded; no ack or snap_done pulse SHALL follow reset release.

Structure
REQ-028 Package sensor_regbank_pkg SHALL hold the ID constant 0xA5, the map offsets (ID=0, NCH=1, FRESH=2, OVR=3, DATA_BASE=4) and a function returning the last valid address for given NUM_CH and CH_BYTES.
REQ-029 Sub-module sensor_chan_reg SHALL implement one channel's live register, fresh/ovr flags and shadow copy, instantiated NUM_CH times by generate.

Verification
REQ-030 Reset then read addresses 0, 1, 4 -> 0xA5, 0x0C, 0x00, each one cycle after rd_req.
REQ-031 ch_valid[0] with 0x1234, then snap_req, then read 4 and 5 -> 0x12, 0x34; read 2 -> 0x01; read 3 -> 0x00.
REQ-032 ch_valid[3] twice (0x0001, then 0xBEEF), then snap_req, then read 10, 11, 3 -> 0xBE, 0xEF, 0x01; second snap_req with no new samples, then read 3 -> 0x00.
REQ-033 ch_valid[2]=0x5555 and snap_req in the same cycle, with prior value 0xAAAA -> address 8 reads 0xAA; next snap_req -> address 8 reads 0x55.
REQ-034 rd_req to addresses 27 and 28 on consecutive cycles (default parameters) -> acks on consecutive cycles; 28 gives rd_data 0x00 with rd_err=1.
REQ-035 Assert rst for one cycle in the cycle after rd_req -> no rd_ack, and all reads after reset return reset values.
